mult_div_unit: RTL

- Parametrised multicycle multiply/divide unit feeding the CPU's HI/LO registers (MIPS MULT/MULTU/DIV/DIVU).
- Control unit pulses start with latched A/B operands, then stalls on busy.
- On done, the control unit asserts hi_w/lo_w to copy the hi/lo outputs.
- Iterative radix-2 datapath: one bit per cycle on operand magnitudes, then a sign fix-up cycle.

---
 rtl/mult_div_pkg.sv | 14 +
 rtl/mult_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes
// and the sequencer states.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit for the HI/LO registers. Works on
// operand magnitudes one bit per cycle, then applies signs in a fix-up cycle.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign a_mag = magnitude(a, ~op[0]);
  assign b_mag = magnitude(b, ~op[0]);

  // Multiply keeps the multiplier in acc low half; divide keeps the dividend
  // there and shifts quotient bits in behind it.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod   = neg_lo_q ? -acc_q : acc_q;
  assign fix_lo = op_q[1] ? (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])
                          : prod[WIDTH-1:0];
  assign fix_hi = op_q[1] ? (neg_hi_q ? -rem_q : rem_q)
                          : prod[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          op_d       = op;
          opb_d      = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          rem_d      = '0;
          cnt_d      = '0;
          neg_lo_d   = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d   = op[1] & ~op[0] & a[WIDTH-1];
          dz_d       = op[1] && (b == '0);
          div_zero_d = 1'b0;
          state_d    = (op[1] && (b == '0)) ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[1]) begin
            if (!div_diff[WIDTH]) begin
              rem_d = div_diff[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST_ITER) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (dz_q) begin
            div_zero_d = 1'b1;
          end else begin
            hi_d = fix_hi;
            lo_d = fix_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
